// File: rtl/xor_frame_accumulator.sv
// xor_frame_accumulator
//
// Streaming XOR reduction engine. Words of a frame arrive on a valid/ready
// input; each word is XOR-folded into a running accumulator. When the beat
// marked in_last is accepted, the folded result and the number of beats are
// registered onto a valid/ready output. The block then holds that result and
// accepts no input until the result is taken.
//
// Parameters:
//   WIDTH   - data word width in bits (>= 1)
//   MAX_LEN - maximum countable beats per frame (>= 1); count saturates here
//   CW      - beat count width, derived from MAX_LEN (not overridable)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept an input beat (low while in reset)
//   in_data    input word
//   in_last    final beat of the frame
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   XOR of all beats in the frame
//   out_count  beats in the frame, saturated at MAX_LEN
//   out_err    overflow flag (only when XOR_FA_OVF_ERR_EN is defined)
//
// Optional feature macro: XOR_FA_OVF_ERR_EN
//   When defined, a sticky overflow flag records that a frame carried more
//   than MAX_LEN beats, and it is reported on out_err with the result.
//   When undefined, overlong frames simply saturate out_count.

module xor_frame_accumulator #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count
`ifdef XOR_FA_OVF_ERR_EN
    ,
    output logic             out_err
`endif
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_next;

`ifdef XOR_FA_OVF_ERR_EN
    logic             ovf;
    logic             ovf_next;
`endif

    // Input is only accepted while accumulating and never during reset, so a
    // beat presented alongside rst is not consumed.
    assign in_ready = (state == ACCUM) && !rst;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // A frame starts with cnt == 0, so the first beat replaces the
    // accumulator instead of folding into it. The count stops at MAX_LEN;
    // later beats still fold into the data.
    assign acc_next = (cnt == '0) ? in_data : (acc ^ in_data);
    assign cnt_next = (cnt == MAX_CNT) ? MAX_CNT : (cnt + CW'(1));

`ifdef XOR_FA_OVF_ERR_EN
    // The sticky flag restarts at each frame's first beat. It sets on any
    // beat accepted once the count is already saturated.
    assign ovf_next = ((cnt == '0) ? 1'b0 : ovf) | (cnt == MAX_CNT);
`endif

    // Single FSM register block. In ACCUM, beats fold into acc/cnt. The last
    // beat moves the folded result to the output registers and enters HOLD.
    // HOLD keeps the result stable until the downstream takes it. Reset has
    // priority over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
`ifdef XOR_FA_OVF_ERR_EN
            ovf       <= 1'b0;
            out_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (in_xfer) begin
                        if (in_last) begin
                            out_data  <= acc_next;
                            out_count <= cnt_next;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                            acc       <= '0;
                            cnt       <= '0;
`ifdef XOR_FA_OVF_ERR_EN
                            out_err   <= ovf_next;
                            ovf       <= 1'b0;
`endif
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt_next;
`ifdef XOR_FA_OVF_ERR_EN
                            ovf <= ovf_next;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_frame_accumulator.sv
// tb_xor_frame_accumulator
//
// Self-checking bench for xor_frame_accumulator with WIDTH=8, MAX_LEN=4.
// The bench uses a table of per-cycle vectors, then hand-written reset
// sequences, then random frames compared against a software XOR model.
// The out_err checks are active only when XOR_FA_OVF_ERR_EN is defined.

module tb_xor_frame_accumulator;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
`ifdef XOR_FA_OVF_ERR_EN
    logic             out_err;
`endif

    int passCount;
    int checkCount;

    typedef struct {
        logic             in_valid;
        logic [WIDTH-1:0] in_data;
        logic             in_last;
        logic             out_ready;
        logic             exp_in_ready;
        logic             exp_out_valid;
        logic [WIDTH-1:0] exp_data;
        logic [CW-1:0]    exp_count;
        logic             exp_err;
    } vec_t;

    vec_t vecs[$];

    xor_frame_accumulator #(
        .WIDTH  (WIDTH),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count)
`ifdef XOR_FA_OVF_ERR_EN
        ,
        .out_err  (out_err)
`endif
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and keep the tallies
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    // Drive all DUT inputs except reset
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Append one per-cycle vector to the table
    task automatic addVec(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic r,
                          input logic eir, input logic eov, input logic [WIDTH-1:0] ed,
                          input logic [CW-1:0] ec, input logic ee);
        vec_t t;
        t.in_valid      = v;
        t.in_data       = d;
        t.in_last       = l;
        t.out_ready     = r;
        t.exp_in_ready  = eir;
        t.exp_out_valid = eov;
        t.exp_data      = ed;
        t.exp_count     = ec;
        t.exp_err       = ee;
        vecs.push_back(t);
    endtask

    // Check the registered result outputs against expected values
    task automatic checkResult(input string tag, input logic ev, input logic [WIDTH-1:0] ed,
                               input logic [CW-1:0] ec, input logic ee);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'(ev));
        checkOutput({tag, "_out_data"},  32'(out_data),  32'(ed));
        checkOutput({tag, "_out_count"}, 32'(out_count), 32'(ec));
`ifdef XOR_FA_OVF_ERR_EN
        checkOutput({tag, "_out_err"},   32'(out_err),   32'(ee));
`else
        if (ee !== ee) checkCount = checkCount;
`endif
    endtask

    // Main test sequence
    initial begin
        logic [WIDTH-1:0] rdata;
        logic [WIDTH-1:0] mdata;
        logic [CW-1:0]    mcnt;
        logic             merr;
        int               flen;
        int               guard;

        passCount  = 0;
        checkCount = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Table rows: stimulus, expected in_ready before the edge, then expected outputs after it
        // Frame 0x0F,0xF0,0x33 -> 0xCC/3
        addVec(1, 8'h0F, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        addVec(1, 8'hF0, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        addVec(1, 8'h33, 1, 1,  1, 1, 8'hCC, 3'd3, 0);
        addVec(0, 8'h00, 0, 1,  0, 0, 8'hCC, 3'd3, 0);
        // Single beat 0xA5
        addVec(1, 8'hA5, 1, 1,  1, 1, 8'hA5, 3'd1, 0);
        addVec(0, 8'h00, 0, 1,  0, 0, 8'hA5, 3'd1, 0);
        // 0x12,0x34 with out_ready low for 5 HOLD cycles while 0x77 is offered
        addVec(1, 8'h12, 0, 0,  1, 0, 8'hA5, 3'd1, 0);
        addVec(1, 8'h34, 1, 0,  1, 1, 8'h26, 3'd2, 0);
        for (int i = 0; i < 5; i++) addVec(1, 8'h77, 1, 0,  0, 1, 8'h26, 3'd2, 0);
        addVec(1, 8'h77, 1, 1,  0, 0, 8'h26, 3'd2, 0);
        addVec(1, 8'h77, 1, 1,  1, 1, 8'h77, 3'd1, 0);
        addVec(0, 8'h00, 0, 1,  0, 0, 8'h77, 3'd1, 0);
        // Back-to-back {0xAA,0x55}, {0x3C} with in_valid held high
        addVec(1, 8'hAA, 0, 1,  1, 0, 8'h77, 3'd1, 0);
        addVec(1, 8'h55, 1, 1,  1, 1, 8'hFF, 3'd2, 0);
        addVec(1, 8'h3C, 1, 1,  0, 0, 8'hFF, 3'd2, 0);
        addVec(1, 8'h3C, 1, 1,  1, 1, 8'h3C, 3'd1, 0);
        addVec(0, 8'h00, 0, 1,  0, 0, 8'h3C, 3'd1, 0);
        // Six beats of 0x01 -> 0x00, count saturates at 4, overflow
        for (int i = 0; i < 5; i++) addVec(1, 8'h01, 0, 1,  1, 0, 8'h3C, 3'd1, 0);
        addVec(1, 8'h01, 1, 1,  1, 1, 8'h00, 3'd4, 1);
        addVec(0, 8'h00, 0, 1,  0, 0, 8'h00, 3'd4, 1);
        // Exactly four beats of 0x01 -> 0x00/4, no overflow
        for (int i = 0; i < 3; i++) addVec(1, 8'h01, 0, 1,  1, 0, 8'h00, 3'd4, 1);
        addVec(1, 8'h01, 1, 1,  1, 1, 8'h00, 3'd4, 0);
        addVec(0, 8'h00, 0, 1,  0, 0, 8'h00, 3'd4, 0);

        // Reset state
        tick();
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkResult("reset", 1'b0, 8'h00, 3'd0, 1'b0);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_last, vecs[i].out_ready);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
            tick();
            checkResult($sformatf("vec%0d", i), vecs[i].exp_out_valid, vecs[i].exp_data,
                        vecs[i].exp_count, vecs[i].exp_err);
        end

        // Reset mid-frame discards the partial 0xFF,0x0F
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h0F, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        checkResult("midrst", 1'b0, 8'h00, 3'd0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
        tick();
        checkResult("after_midrst", 1'b1, 8'h55, 3'd1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        // Reset while holding a result drops it
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
        tick();
        checkResult("hold_pre_rst", 1'b1, 8'h11, 3'd1, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        checkResult("hold_rst", 1'b0, 8'h00, 3'd0, 1'b0);
        #1;
        checkOutput("hold_rst_in_ready", 32'(in_ready), 32'd1);

        // Random frames of length 1..6 against a software XOR model
        for (int f = 0; f < 200; f++) begin
            flen  = $urandom_range(1, 6);
            mdata = '0;
            mcnt  = '0;
            merr  = 1'b0;
            for (int b = 0; b < flen; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b1);
                    tick();
                end
                rdata = 8'($urandom);
                applyStimulus(1'b1, rdata, (b == flen - 1), 1'b1);
                #1;
                guard = 0;
                while (!in_ready && guard < 20) begin
                    tick();
                    guard++;
                end
                checkOutput($sformatf("rand%0d_beat%0d_in_ready", f, b), 32'(in_ready), 32'd1);
                mdata = mdata ^ rdata;
                if (32'(mcnt) == MAX_LEN) merr = 1'b1;
                else mcnt = mcnt + 3'd1;
                tick();
            end
            checkResult($sformatf("rand%0d", f), 1'b1, mdata, mcnt, merr);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            for (int k = $urandom_range(0, 2); k > 0; k--) tick();
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
